// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin sequencer sharing one I2C master among NREQ requesters
`timescale 1ns/1ps
module i2c_master_arbiter #(
  parameter int NREQ        = 4,
  parameter int NEWD_CYCLES = 5,
  parameter int TIMEOUT     = 4096,
  localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_op_i,
  input  logic [7*NREQ-1:0] req_addr_i,
  input  logic [8*NREQ-1:0] req_din_i,
  output logic [NREQ-1:0]   req_accept_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [7:0]        rsp_dout_o,
  output logic              rsp_ack_err_o,
  output logic              rsp_timeout_o,
  output logic              m_newd_o,
  output logic              m_op_o,
  output logic [6:0]        m_addr_o,
  output logic [7:0]        m_din_o,
  input  logic [7:0]        m_dout_i,
  input  logic              m_busy_i,
  input  logic              m_ack_err_i,
  input  logic              m_done_i,
  output logic              arb_busy_o,
  output logic [IDW-1:0]    cur_id_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int NW = $clog2(NEWD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d, cur_id_q, cur_id_d;
  logic              op_q, op_d;
  logic [6:0]        addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              newd_q, newd_d;
  logic [NW-1:0]     newd_cnt_q, newd_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              done_q;
  logic              seen_q, seen_d;
  logic [7:0]        cap_dout_q, cap_dout_d;
  logic              cap_err_q, cap_err_d;
  logic [NREQ-1:0]   accept_q, accept_d, rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_dout_q, rsp_dout_d;
  logic              rsp_err_q, rsp_err_d, rsp_to_q, rsp_to_d;

  logic              done_rise;
  logic              found;
  logic [IDW-1:0]    grant;
  logic [IDW:0]      scan_idx;

  assign done_rise = m_done_i & ~done_q;

  // First pending requester at or after rr_ptr, wrapping past NREQ-1.
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (scan_idx >= (IDW+1)'(NREQ)) scan_idx = scan_idx - (IDW+1)'(NREQ);
      if (!found && req_valid_i[scan_idx[IDW-1:0]]) begin
        found = 1'b1;
        grant = scan_idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      newd_q      <= 1'b0;
      newd_cnt_q  <= '0;
      to_cnt_q    <= '0;
      done_q      <= 1'b0;
      seen_q      <= 1'b0;
      cap_dout_q  <= '0;
      cap_err_q   <= 1'b0;
      accept_q    <= '0;
      rsp_valid_q <= '0;
      rsp_dout_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      newd_q      <= newd_d;
      newd_cnt_q  <= newd_cnt_d;
      to_cnt_q    <= to_cnt_d;
      done_q      <= m_done_i;
      seen_q      <= seen_d;
      cap_dout_q  <= cap_dout_d;
      cap_err_q   <= cap_err_d;
      accept_q    <= accept_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dout_q  <= rsp_dout_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    op_d        = op_q;
    addr_d      = addr_q;
    din_d       = din_q;
    newd_d      = 1'b0;
    newd_cnt_d  = newd_cnt_q;
    to_cnt_d    = to_cnt_q;
    seen_d      = seen_q;
    cap_dout_d  = cap_dout_q;
    cap_err_d   = cap_err_q;
    accept_d    = '0;
    rsp_valid_d = '0;
    rsp_dout_d  = rsp_dout_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    case (state_q)
      S_IDLE: begin
        if (found && !m_busy_i) begin
          state_d         = S_ISSUE;
          cur_id_d        = grant;
          op_d            = req_op_i[grant];
          addr_d          = req_addr_i[7*int'(grant) +: 7];
          din_d           = req_din_i[8*int'(grant) +: 8];
          newd_d          = 1'b1;
          newd_cnt_d      = NW'(1);
          to_cnt_d        = '0;
          seen_d          = 1'b0;
          accept_d[grant] = 1'b1;
        end
      end
      S_ISSUE: begin
        to_cnt_d = to_cnt_q + TW'(1);
        // A done that arrives while newd is still asserted is parked until WAIT.
        if (done_rise) begin
          seen_d     = 1'b1;
          cap_dout_d = op_q ? m_dout_i : 8'h00;
          cap_err_d  = m_ack_err_i;
        end
        if (newd_cnt_q == NW'(NEWD_CYCLES)) begin
          state_d = S_WAIT;
        end else begin
          newd_d     = 1'b1;
          newd_cnt_d = newd_cnt_q + NW'(1);
        end
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (seen_q || done_rise) begin
          state_d               = S_RESP;
          rsp_valid_d[cur_id_q] = 1'b1;
          rsp_to_d              = 1'b0;
          rsp_dout_d            = seen_q ? cap_dout_q : (op_q ? m_dout_i : 8'h00);
          rsp_err_d             = seen_q ? cap_err_q : m_ack_err_i;
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d               = S_RESP;
          rsp_valid_d[cur_id_q] = 1'b1;
          rsp_to_d              = 1'b1;
          rsp_dout_d            = 8'h00;
          rsp_err_d             = 1'b0;
        end
      end
      S_RESP: begin
        state_d    = S_IDLE;
        rr_ptr_d   = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + IDW'(1);
        op_d       = 1'b0;
        addr_d     = '0;
        din_d      = '0;
        seen_d     = 1'b0;
        rsp_dout_d = 8'h00;
        rsp_err_d  = 1'b0;
        rsp_to_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_accept_o  = accept_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dout_o    = rsp_dout_q;
  assign rsp_ack_err_o = rsp_err_q;
  assign rsp_timeout_o = rsp_to_q;
  assign m_newd_o      = newd_q;
  assign m_op_o        = op_q;
  assign m_addr_o      = addr_q;
  assign m_din_o       = din_q;
  assign arb_busy_o    = (state_q != S_IDLE);
  assign cur_id_o      = cur_id_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - directed bench for i2c_master_arbiter with a simple master model
`timescale 1ns/1ps
module tb_i2c_master_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_op = '0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_din = '0;
  logic [3:0]  req_accept, rsp_valid;
  logic [7:0]  rsp_dout;
  logic        rsp_ack_err, rsp_timeout;
  logic        m_newd, m_op;
  logic [6:0]  m_addr;
  logic [7:0]  m_din;
  logic [7:0]  m_dout = '0;
  logic        m_busy = 1'b0, m_ack_err = 1'b0, m_done = 1'b0;
  logic        arb_busy;
  logic [1:0]  cur_id;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.NREQ(NREQ), .NEWD_CYCLES(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_addr_i(req_addr), .req_din_i(req_din),
    .req_accept_o(req_accept), .rsp_valid_o(rsp_valid), .rsp_dout_o(rsp_dout),
    .rsp_ack_err_o(rsp_ack_err), .rsp_timeout_o(rsp_timeout),
    .m_newd_o(m_newd), .m_op_o(m_op), .m_addr_o(m_addr), .m_din_o(m_din),
    .m_dout_i(m_dout), .m_busy_i(m_busy), .m_ack_err_i(m_ack_err), .m_done_i(m_done),
    .arb_busy_o(arb_busy), .cur_id_o(cur_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Master model: pulses done for one cycle, three cycles after newd falls.
  logic model_en = 1'b0;
  logic newd_prev = 1'b0;
  int   model_cnt = 0;
  always @(posedge clk) begin
    #1;
    m_done = 1'b0;
    if (rst) begin
      model_cnt = 0;
    end else if (model_en) begin
      if (newd_prev && !m_newd) begin
        model_cnt = 3;
      end else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) m_done = 1'b1;
      end
    end
    newd_prev = m_newd;
  end

  logic [3:0] persist = '0;
  logic [3:0] t_acc, t_rv;
  logic [7:0] t_dout, t_din;
  logic [6:0] t_addr, t_addr_rsp;
  logic       t_op, t_err, t_to, t_got;
  logic [1:0] t_id;
  int         t_acc_k, t_newd_k, t_newd_n, t_done_k, t_rsp_k;

  task automatic run_txn(input int max);
    t_acc = '0; t_rv = '0; t_dout = '0; t_din = '0; t_addr = '0; t_addr_rsp = '0;
    t_op = 1'b0; t_err = 1'b0; t_to = 1'b0; t_got = 1'b0; t_id = '0;
    t_acc_k = -1; t_newd_k = -1; t_newd_n = 0; t_done_k = -1; t_rsp_k = -1;
    for (int k = 0; k < max && !t_got; k++) begin
      @(negedge clk);
      if (req_accept != 4'b0 && t_acc_k < 0) begin
        t_acc     = req_accept;
        t_acc_k   = k;
        req_valid = req_valid & ~(req_accept & ~persist);
      end
      if (m_newd) begin
        if (t_newd_k < 0) t_newd_k = k;
        t_newd_n++;
        t_op   = m_op;
        t_addr = m_addr;
        t_din  = m_din;
      end
      if (m_done && t_done_k < 0) t_done_k = k;
      if (rsp_valid != 4'b0) begin
        t_rv       = rsp_valid;
        t_dout     = rsp_dout;
        t_err      = rsp_ack_err;
        t_to       = rsp_timeout;
        t_addr_rsp = m_addr;
        t_id       = cur_id;
        t_rsp_k    = k;
        t_got      = 1'b1;
      end
    end
  endtask

  int ord3[5] = '{0, 1, 2, 3, 0};
  int ord4[4] = '{1, 3, 1, 3};
  logic seen_any;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {req_accept, rsp_valid, rsp_dout, rsp_ack_err, rsp_timeout,
                            m_newd, m_op, m_addr, m_din, arb_busy, cur_id}, 64'd0);
    rst = 1'b0;

    // 1: lone write from requester 2
    m_dout = 8'h77; m_ack_err = 1'b0; model_en = 1'b1;
    req_op[2] = 1'b0; req_addr[20:14] = 7'd3; req_din[23:16] = 8'd5; req_valid = 4'b0100;
    run_txn(60);
    check("t1_got", t_got, 1);
    check("t1_accept", t_acc, 4'b0100);
    check("t1_newd_len", t_newd_n, 5);
    check("t1_newd_with_accept", t_newd_k, t_acc_k);
    check("t1_op", t_op, 0);
    check("t1_addr", t_addr, 7'd3);
    check("t1_din", t_din, 8'd5);
    check("t1_rsp_valid", t_rv, 4'b0100);
    check("t1_dout", t_dout, 8'h00);
    check("t1_rsp_latency", t_rsp_k - t_done_k, 1);
    check("t1_addr_held", t_addr_rsp, 7'd3);
    @(negedge clk);
    check("t1_cleared", {rsp_valid, rsp_dout, rsp_ack_err, rsp_timeout, m_op, m_addr, m_din, arb_busy}, 64'd0);

    // 2: read from requester 1 with ack error
    m_dout = 8'hA5; m_ack_err = 1'b1;
    req_op[1] = 1'b1; req_addr[13:7] = 7'd2; req_valid = 4'b0010;
    run_txn(60);
    check("t2_got", t_got, 1);
    check("t2_op", t_op, 1);
    check("t2_addr", t_addr, 7'd2);
    check("t2_rsp_valid", t_rv, 4'b0010);
    check("t2_dout", t_dout, 8'hA5);
    check("t2_ack_err", t_err, 1);
    check("t2_timeout", t_to, 0);

    // 3: all requesters held after reset
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    m_ack_err = 1'b0; m_dout = 8'h3C; req_op = '0;
    persist = 4'b1111; req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      run_txn(60);
      if (n == 4) req_valid = '0;
      check("t3_got", t_got, 1);
      check("t3_accept", t_acc, 4'b0001 << ord3[n]);
      check("t3_rsp_valid", t_rv, 4'b0001 << ord3[n]);
      check("t3_cur_id", t_id, ord3[n]);
    end

    // 4: requesters 1 and 3 persistent
    persist = 4'b1010; req_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      run_txn(60);
      if (n == 3) req_valid = '0;
      check("t4_accept", t_acc, 4'b0001 << ord4[n]);
      check("t4_rsp_valid", t_rv, 4'b0001 << ord4[n]);
    end

    // 5: master never completes, then next pending request served
    persist = '0; model_en = 1'b0; m_ack_err = 1'b1; req_valid = 4'b0101;
    run_txn(200);
    model_en = 1'b1; m_ack_err = 1'b0;
    check("t5_got", t_got, 1);
    check("t5_rsp_valid", t_rv, 4'b0001);
    check("t5_timeout", t_to, 1);
    check("t5_dout", t_dout, 8'h00);
    check("t5_ack_err", t_err, 0);
    check("t5_timeout_latency", t_rsp_k - t_acc_k, TMO);
    run_txn(60);
    check("t5_next_rsp_valid", t_rv, 4'b0100);
    check("t5_next_timeout", t_to, 0);

    // 6: reset during WAIT, then m_busy blocks grants
    model_en = 1'b0; req_addr[27:21] = 7'h55; req_valid = 4'b1000;
    t_acc = '0;
    for (int k = 0; k < 20 && t_acc == 4'b0; k++) begin
      @(negedge clk);
      t_acc = req_accept;
    end
    check("t6_accept", t_acc, 4'b1000);
    repeat (6) @(negedge clk);
    check("t6_in_wait", {arb_busy, m_newd, m_addr}, {1'b1, 1'b0, 7'h55});
    #2 rst = 1'b1;
    #1;
    check("t6_reset_outputs", {req_accept, rsp_valid, rsp_dout, rsp_ack_err, rsp_timeout,
                               m_newd, m_op, m_addr, m_din, arb_busy, cur_id}, 64'd0);
    req_valid = 4'b1010; m_busy = 1'b1; model_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_any = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen_any = seen_any | (|req_accept) | (|rsp_valid) | arb_busy;
    end
    check("t6_busy_blocks", seen_any, 0);
    m_busy = 1'b0;
    run_txn(60);
    check("t6_rr_reset_grant", t_acc, 4'b0010);
    check("t6_rsp_valid", t_rv, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
